// File: rtl/decrypter_pkg.sv
// Shared widths, S-box table, FSM encoding and key-schedule helpers for the decrypter.
package decrypter_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned HALF_W  = 32;
    localparam int unsigned KEY_W   = 64;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned CNT_W   = 4;

    localparam logic [NIB_W-1:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [HALF_W-1:0] rotl32(input logic [HALF_W-1:0] x,
                                                  input logic [4:0]        sh);
        return HALF_W'(({x, x} << sh) >> HALF_W);
    endfunction

    // Upper half of the key rotated left by 8*i bits (i in 0..15 wraps mod 64).
    function automatic logic [HALF_W-1:0] subkey(input logic [KEY_W-1:0] key,
                                                  input logic [CNT_W-1:0] i);
        logic [5:0] sh;
        sh = 6'({i, 3'b000});
        return HALF_W'(({key, key} << sh) >> (2 * KEY_W - HALF_W));
    endfunction

endpackage

// File: rtl/decrypter_round_f.sv
// Combinational Feistel round function F(x,k) = rotl32(S(x^k), 3) + x.
module decrypter_round_f
    import decrypter_pkg::*;
(
    input  logic [HALF_W-1:0] i_x,
    input  logic [HALF_W-1:0] i_k,
    output logic [HALF_W-1:0] o_f_c
);

    logic [HALF_W-1:0] w_mix;
    logic [HALF_W-1:0] w_sub;

    assign w_mix = i_x ^ i_k;

    // Nibble-wise substitution layer.
    always_comb begin
        w_sub = '0;
        for (int n = 0; n < int'(HALF_W / NIB_W); n++) begin
            w_sub[n*NIB_W +: NIB_W] = SBOX[w_mix[n*NIB_W +: NIB_W]];
        end
    end

    assign o_f_c = rotl32(w_sub, 5'd3) + i_x;

endmodule

// File: rtl/decrypter.sv
// Iterative Feistel block decrypter, one round per clock.
// Define DECRYPTER_WHITEN_EN to XOR the latched key onto the final plaintext.
module decrypter
    import decrypter_pkg::*;
#(
    parameter int unsigned ROUNDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   round_key,
    output logic [BLOCK_W-1:0] data_out,
    output logic               status
);

    state_t             r_state,    w_state_nxt;
    logic [HALF_W-1:0]  r_l,        w_l_nxt;
    logic [HALF_W-1:0]  r_r,        w_r_nxt;
    logic [KEY_W-1:0]   r_key,      w_key_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [BLOCK_W-1:0] r_data_out, w_out_nxt;
    logic               r_status,   w_status_nxt;

    logic [HALF_W-1:0]  w_f;
    logic [HALF_W-1:0]  w_new_l;
    logic [BLOCK_W-1:0] w_result;

    decrypter_round_f u_round_f (
        .i_x   (r_l),
        .i_k   (subkey(r_key, r_cnt)),
        .o_f_c (w_f)
    );

    assign w_new_l = r_r ^ w_f;

`ifdef DECRYPTER_WHITEN_EN
    assign w_result = {w_new_l, r_l} ^ r_key;
`else
    assign w_result = {w_new_l, r_l};
`endif

    // A set edge always wins over an in-flight round and restarts the block.
    always_comb begin
        w_state_nxt  = r_state;
        w_l_nxt      = r_l;
        w_r_nxt      = r_r;
        w_key_nxt    = r_key;
        w_cnt_nxt    = r_cnt;
        w_out_nxt    = r_data_out;
        w_status_nxt = r_status;
        if (set) begin
            w_state_nxt  = ST_RUN;
            w_l_nxt      = data_in[BLOCK_W-1:HALF_W];
            w_r_nxt      = data_in[HALF_W-1:0];
            w_key_nxt    = round_key;
            w_cnt_nxt    = CNT_W'(ROUNDS - 1);
            w_status_nxt = 1'b0;
        end else if (r_state == ST_RUN) begin
            w_l_nxt   = w_new_l;
            w_r_nxt   = r_l;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                w_state_nxt  = ST_IDLE;
                w_out_nxt    = w_result;
                w_status_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_l        <= '0;
            r_r        <= '0;
            r_key      <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_status   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_l        <= w_l_nxt;
            r_r        <= w_r_nxt;
            r_key      <= w_key_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data_out <= w_out_nxt;
            r_status   <= w_status_nxt;
        end
    end

    assign data_out = r_data_out;
    assign status   = r_status;

endmodule

// File: tb/tb_decrypter.sv
// Bench for decrypter: 8-round and 1-round instances against a behavioural Feistel model.
// Honours DECRYPTER_WHITEN_EN in the expected values.
module tb_decrypter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0;
    logic [63:0] data_in = '0;
    logic [63:0] round_key = '0;
    logic [63:0] out8, out1;
    logic        st8, st1;

    int n_tests = 0;
    int n_fail  = 0;

    int m_sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    logic [63:0] exp_out8 = '0;
    logic [63:0] exp_out1 = '0;

    always #5 clk = ~clk;

    decrypter #(.ROUNDS(8)) u_dut8 (
        .clk(clk), .rst(rst), .set(set), .data_in(data_in),
        .round_key(round_key), .data_out(out8), .status(st8)
    );

    decrypter #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .set(set), .data_in(data_in),
        .round_key(round_key), .data_out(out1), .status(st1)
    );

    function automatic logic [31:0] m_f(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] t;
        logic [31:0] s;
        t = x ^ k;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            s = s | (32'(m_sb[int'((t >> (4 * n)) & 32'hF)]) << (4 * n));
        end
        return ((s << 3) | (s >> 29)) + x;
    endfunction

    function automatic logic [31:0] m_key(input logic [63:0] key, input int i);
        int          s;
        logic [63:0] r;
        s = (8 * i) % 64;
        r = (s == 0) ? key : ((key << s) | (key >> (64 - s)));
        return r[63:32];
    endfunction

    function automatic logic [63:0] m_decrypt(input logic [63:0] ct, input logic [63:0] key,
                                              input int rounds);
        logic [31:0] l, r, t;
        l = ct[63:32];
        r = ct[31:0];
        for (int i = rounds - 1; i >= 0; i--) begin
            t = l;
            l = r ^ m_f(l, m_key(key, i));
            r = t;
        end
`ifdef DECRYPTER_WHITEN_EN
        return {l, r} ^ key;
`else
        return {l, r};
`endif
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [63:0] key,
                                              input int rounds);
        logic [31:0] l, r, t;
        l = pt[63:32];
        r = pt[31:0];
        for (int i = 0; i < rounds; i++) begin
            t = r;
            r = l ^ m_f(r, m_key(key, i));
            l = t;
        end
        return {l, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] ct, input logic [63:0] key);
        set       = 1'b1;
        data_in   = ct;
        round_key = key;
        step();
        set       = 1'b0;
        data_in   = {$urandom, $urandom};
        round_key = {$urandom, $urandom};
        chk("load_status8", 64'(st8), 64'd0);
    endtask

    // Eight edges after a load: busy with old output held, then the new result.
    task automatic run_rest(input string tag, input logic [63:0] ct, input logic [63:0] key);
        logic [63:0] e8;
        e8       = m_decrypt(ct, key, 8);
        exp_out1 = m_decrypt(ct, key, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                chk({tag, "_st1"}, 64'(st1), 64'd1);
                chk({tag, "_out1"}, out1, exp_out1);
            end
            if (k < 8) begin
                chk({tag, "_busy"}, 64'(st8), 64'd0);
                chk({tag, "_held"}, out8, exp_out8);
            end else begin
                chk({tag, "_done"}, 64'(st8), 64'd1);
                chk({tag, "_out8"}, out8, e8);
            end
        end
        exp_out8 = e8;
    endtask

    task automatic run_vec(input string tag, input logic [63:0] ct, input logic [63:0] key);
        load(ct, key);
        run_rest(tag, ct, key);
    endtask

    initial begin
        logic [63:0] ct, key, pt;

        // Power-on reset
        rst = 1'b1;
        step();
        step();
        chk("rst_st8", 64'(st8), 64'd0);
        chk("rst_out8", out8, 64'd0);
        chk("rst_st1", 64'(st1), 64'd0);
        chk("rst_out1", out1, 64'd0);
        rst = 1'b0;

        // All-zero block and key; the 1-round result is a known constant
        run_vec("zero", 64'd0, 64'd0);
        chk("zero_r1_const", out1, 64'h6666666600000000);

        run_vec("dir", 64'h337833fff0d55a55, 64'h0102030405060708);

        // Round trip through the model's encryptor
        pt  = 64'h0123456789ABCDEF;
        key = 64'h0F1E2D3C4B5A6978;
        ct  = m_encrypt(pt, key, 8);
        run_vec("rtrip", ct, key);
`ifdef DECRYPTER_WHITEN_EN
        chk("rtrip_plain", out8, pt ^ key);
`else
        chk("rtrip_plain", out8, pt);
`endif

        for (int v = 0; v < 6; v++) begin
            run_vec("rand", {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Restart on the 4th edge of a run
        load({$urandom, $urandom}, {$urandom, $urandom});
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("restart_busy", 64'(st8), 64'd0);
            chk("restart_held", out8, exp_out8);
        end
        ct  = {$urandom, $urandom};
        key = {$urandom, $urandom};
        load(ct, key);
        run_rest("restart", ct, key);

        // Hold after done while inputs toggle
        for (int k = 0; k < 20; k++) begin
            data_in   = {$urandom, $urandom};
            round_key = {$urandom, $urandom};
            step();
            chk("hold_st8", 64'(st8), 64'd1);
            chk("hold_out8", out8, exp_out8);
            chk("hold_out1", out1, exp_out1);
        end

        // Reset mid-run aborts the computation
        load({$urandom, $urandom}, {$urandom, $urandom});
        step();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("midrst_st8", 64'(st8), 64'd0);
        chk("midrst_out8", out8, 64'd0);
        chk("midrst_st1", 64'(st1), 64'd0);
        chk("midrst_out1", out1, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("abort_st8", 64'(st8), 64'd0);
            chk("abort_out8", out8, 64'd0);
        end
        exp_out8 = '0;

        // Back-to-back set edges: only the last one counts
        set = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in   = {$urandom, $urandom};
            round_key = {$urandom, $urandom};
            step();
        end
        ct  = data_in;
        key = round_key;
        set = 1'b0;
        run_rest("heldset", ct, key);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
